// File: rtl/uart_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : uart_pkg
//  Brief    : Shared definitions for the 16750 UART receive path: entry field
//             positions, FIFO operating modes and the RDA trigger lookup.
//  Revision : 1.0 - initial release
// ============================================================================
package uart_pkg;

    // Positions of the per-character error flags inside a stored entry.
    // Bits 7..0 carry the received character itself.
    localparam int c_PE_BIT = 8;
    localparam int c_FE_BIT = 9;
    localparam int c_BI_BIT = 10;

    // Operating mode derived from FCR[0] and FCR[5].
    typedef enum logic [1:0] {
        HOLD = 2'd0,    // single-entry holding register
        F16  = 2'd1,    // 16-entry FIFO
        F64  = 2'd2     // full-depth FIFO
    } uart_fifo_mode_t;

    // RDA trigger level for a given mode and FCR[7:6] setting.
    // Holding-register mode signals data as soon as one entry is present.
    function automatic logic [7:0] trig_level(input uart_fifo_mode_t mode,
                                              input logic [1:0]      trig);
        logic [7:0] lvl;
        lvl = 8'd1;
        if (mode == F64) begin
            case (trig)
                2'd0:    lvl = 8'd1;
                2'd1:    lvl = 8'd16;
                2'd2:    lvl = 8'd32;
                default: lvl = 8'd56;
            endcase
        end else if (mode == F16) begin
            case (trig)
                2'd0:    lvl = 8'd1;
                2'd1:    lvl = 8'd4;
                2'd2:    lvl = 8'd8;
                default: lvl = 8'd14;
            endcase
        end
        return lvl;
    endfunction

endpackage
`default_nettype wire

// File: rtl/uart_fifo_mem.sv
`default_nettype none
// ============================================================================
//  Module   : uart_fifo_mem
//  Brief    : DEPTH x WIDTH register-array storage for the receive FIFO.
//             One synchronous write port, one asynchronous read port so the
//             head entry falls through to the output without a cycle of delay.
//  Revision : 1.0 - initial release
// ============================================================================
module uart_fifo_mem #(
    parameter int DEPTH = 64,
    parameter int WIDTH = 11
) (
    input  logic                     clk,
    input  logic                     i_we,
    input  logic [$clog2(DEPTH)-1:0] i_waddr,
    input  logic [WIDTH-1:0]         i_wdata,
    input  logic [$clog2(DEPTH)-1:0] i_raddr,
    output logic [WIDTH-1:0]         o_rdata
);

    // Storage is deliberately not reset: the top level masks the read data
    // whenever the FIFO is empty, so stale contents are never visible.
    logic [WIDTH-1:0] r_mem [DEPTH];

    // Write the pushed entry at the tail address.
    always_ff @(posedge clk) begin
        if (i_we) begin
            r_mem[i_waddr] <= i_wdata;
        end
    end

    assign o_rdata = r_mem[i_raddr];

endmodule
`default_nettype wire

// File: rtl/uart_rx_fifo.sv
`default_nettype none
// ============================================================================
//  Module   : uart_rx_fifo
//  Brief    : 16750 UART receive buffer. Stores characters with BI/FE/PE flags,
//             serves RBR reads first-word-fall-through, and produces RDA, CTI,
//             overrun and FIFO-error status for the interrupt and LSR logic.
//  Revision : 1.0 - initial release
// ============================================================================
module uart_rx_fifo
    import uart_pkg::*;
#(
    parameter int DEPTH = 64,
    parameter int WIDTH = 11
) (
    input  logic                       CLK,
    input  logic                       RST,
    input  logic                       FIFO_EN,
    input  logic                       FIFO64,
    input  logic [1:0]                 TRIG,
    input  logic                       CLEAR,
    input  logic                       RX_WE,
    input  logic [WIDTH-1:0]           RX_DATA,
    input  logic                       RD,
    input  logic                       CHAR_TICK,
    output logic [WIDTH-1:0]           DOUT,
    output logic                       EMPTY,
    output logic                       FULL,
    output logic [$clog2(DEPTH):0]     COUNT,
    output logic                       RDA,
    output logic                       CTI,
    output logic                       OE,
    output logic                       FIFO_ERR
);

    localparam int c_AW = $clog2(DEPTH);
    localparam int c_CW = c_AW + 1;

    localparam logic [c_AW-1:0] c_ONE_A  = 1;
    localparam logic [c_CW-1:0] c_ONE_C  = 1;
    localparam logic [2:0]      c_TO_MAX = 3'd4;

    // ------------------------------------------------------------------
    // State
    // ------------------------------------------------------------------
    logic [c_AW-1:0] r_head;
    logic [c_AW-1:0] r_tail;
    logic [c_CW-1:0] r_count;
    logic [c_CW-1:0] r_err_cnt;
    logic [2:0]      r_to_cnt;
    logic            r_fifo_en_q;
    logic            r_fifo64_q;
    logic            r_rda;
    logic            r_cti;
    logic            r_oe;
    logic            r_fifo_err;

    // ------------------------------------------------------------------
    // Combinational control
    // ------------------------------------------------------------------
    uart_fifo_mode_t w_mode;
    logic [c_CW-1:0] w_cap;
    logic [7:0]      w_trig;
    logic            w_empty;
    logic            w_full;
    logic            w_flush;
    logic            w_pop;
    logic            w_push;
    logic            w_ovr;
    logic            w_push_err;
    logic            w_pop_err;
    logic [WIDTH-1:0] w_head_data;
    logic [c_AW-1:0] w_head_nxt;
    logic [c_AW-1:0] w_tail_nxt;
    logic            w_rda_nxt;
    logic            w_cti_nxt;
    logic            w_err_nxt;

    // Mode and active capacity follow the FCR bits directly.
    always_comb begin
        w_mode = HOLD;
        w_cap  = c_ONE_C;
        if (FIFO_EN && FIFO64) begin
            w_mode = F64;
            w_cap  = c_CW'(DEPTH);
        end else if (FIFO_EN) begin
            w_mode = F16;
            w_cap  = c_CW'(16);
        end
    end

    assign w_trig  = trig_level(w_mode, TRIG);
    assign w_empty = (r_count == '0);
    assign w_full  = (r_count == w_cap);

    // Any change of FIFO_EN or FIFO64 flushes exactly like an FCR[1] write.
    assign w_flush = CLEAR || (FIFO_EN != r_fifo_en_q) || (FIFO64 != r_fifo64_q);

    // A pop frees a slot in the same cycle, so a push against a full FIFO
    // still lands when it coincides with a read.
    assign w_pop  = !w_flush && RD && !w_empty;
    assign w_push = !w_flush && RX_WE && (!w_full || w_pop);
    assign w_ovr  = !w_flush && RX_WE && w_full && !w_pop;

    assign w_push_err = |RX_DATA[c_BI_BIT:c_PE_BIT];
    assign w_pop_err  = |w_head_data[c_BI_BIT:c_PE_BIT];

    // Pointers wrap at the active capacity, not at the physical depth.
    assign w_head_nxt = (({1'b0, r_head} + c_ONE_C) == w_cap) ? '0 : r_head + c_ONE_A;
    assign w_tail_nxt = (({1'b0, r_tail} + c_ONE_C) == w_cap) ? '0 : r_tail + c_ONE_A;

    // Status flags are registered from the current state, so they trail
    // COUNT by one cycle.
    assign w_rda_nxt = FIFO_EN ? (32'(r_count) >= 32'(w_trig)) : !w_empty;
    assign w_cti_nxt = (r_to_cnt == c_TO_MAX) && !w_empty && FIFO_EN;
    assign w_err_nxt = (r_err_cnt != '0) && FIFO_EN;

    // ------------------------------------------------------------------
    // Storage
    // ------------------------------------------------------------------
    uart_fifo_mem #(
        .DEPTH (DEPTH),
        .WIDTH (WIDTH)
    ) u_mem (
        .clk     (CLK),
        .i_we    (w_push),
        .i_waddr (r_tail),
        .i_wdata (RX_DATA),
        .i_raddr (r_head),
        .o_rdata (w_head_data)
    );

    // ------------------------------------------------------------------
    // Sequential logic
    // ------------------------------------------------------------------

    // Head/tail pointers and occupancy.
    always_ff @(posedge CLK) begin
        if (RST || w_flush) begin
            r_head  <= '0;
            r_tail  <= '0;
            r_count <= '0;
        end else begin
            if (w_pop) begin
                r_head <= w_head_nxt;
            end
            if (w_push) begin
                r_tail <= w_tail_nxt;
            end
            if (w_push && !w_pop) begin
                r_count <= r_count + c_ONE_C;
            end else if (w_pop && !w_push) begin
                r_count <= r_count - c_ONE_C;
            end
        end
    end

    // Number of stored entries carrying at least one error flag.
    always_ff @(posedge CLK) begin
        if (RST || w_flush) begin
            r_err_cnt <= '0;
        end else begin
            if ((w_push && w_push_err) && !(w_pop && w_pop_err)) begin
                r_err_cnt <= r_err_cnt + c_ONE_C;
            end else if ((w_pop && w_pop_err) && !(w_push && w_push_err)) begin
                r_err_cnt <= r_err_cnt - c_ONE_C;
            end
        end
    end

    // Character-time counter since the last FIFO access, saturating at 4.
    always_ff @(posedge CLK) begin
        if (RST || w_flush || w_push || w_pop || w_empty) begin
            r_to_cnt <= '0;
        end else if (CHAR_TICK && (r_to_cnt != c_TO_MAX)) begin
            r_to_cnt <= r_to_cnt + 3'd1;
        end
    end

    // Previous FCR mode bits, used to detect a mode switch. Reset captures
    // the current inputs so leaving reset is not itself seen as a switch.
    always_ff @(posedge CLK) begin
        if (RST) begin
            r_fifo_en_q <= FIFO_EN;
            r_fifo64_q  <= FIFO64;
        end else begin
            r_fifo_en_q <= FIFO_EN;
            r_fifo64_q  <= FIFO64;
        end
    end

    // Registered RDA, CTI, FIFO error and overrun indications.
    always_ff @(posedge CLK) begin
        if (RST) begin
            r_rda      <= 1'b0;
            r_cti      <= 1'b0;
            r_fifo_err <= 1'b0;
            r_oe       <= 1'b0;
        end else begin
            r_rda      <= w_rda_nxt;
            r_cti      <= w_cti_nxt;
            r_fifo_err <= w_err_nxt;
            r_oe       <= w_ovr;
        end
    end

    // ------------------------------------------------------------------
    // Outputs
    // ------------------------------------------------------------------
    assign DOUT     = w_empty ? '0 : w_head_data;
    assign EMPTY    = w_empty;
    assign FULL     = w_full;
    assign COUNT    = r_count;
    assign RDA      = r_rda;
    assign CTI      = r_cti;
    assign OE       = r_oe;
    assign FIFO_ERR = r_fifo_err;

endmodule
`default_nettype wire

// File: tb/tb_uart_rx_fifo.sv
`default_nettype none
// ============================================================================
//  Module   : tb_uart_rx_fifo
//  Brief    : Self-checking bench for uart_rx_fifo. Directed scenarios plus a
//             randomized run compared against a queue-based reference model.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_uart_rx_fifo;

    logic        CLK = 1'b0;
    logic        RST;
    logic        FIFO_EN;
    logic        FIFO64;
    logic [1:0]  TRIG;
    logic        CLEAR;
    logic        RX_WE;
    logic [10:0] RX_DATA;
    logic        RD;
    logic        CHAR_TICK;
    logic [10:0] DOUT;
    logic        EMPTY;
    logic        FULL;
    logic [6:0]  COUNT;
    logic        RDA;
    logic        CTI;
    logic        OE;
    logic        FIFO_ERR;

    int checks   = 0;
    int failures = 0;

    uart_rx_fifo #(.DEPTH(64), .WIDTH(11)) dut (
        .CLK       (CLK),
        .RST       (RST),
        .FIFO_EN   (FIFO_EN),
        .FIFO64    (FIFO64),
        .TRIG      (TRIG),
        .CLEAR     (CLEAR),
        .RX_WE     (RX_WE),
        .RX_DATA   (RX_DATA),
        .RD        (RD),
        .CHAR_TICK (CHAR_TICK),
        .DOUT      (DOUT),
        .EMPTY     (EMPTY),
        .FULL      (FULL),
        .COUNT     (COUNT),
        .RDA       (RDA),
        .CTI       (CTI),
        .OE        (OE),
        .FIFO_ERR  (FIFO_ERR)
    );

    always #5 CLK = ~CLK;

    // ------------------------------------------------------------------
    // Reference model: the buffer is a queue; error status is recounted
    // from the queue contents; status flags are taken from pre-edge state.
    // ------------------------------------------------------------------
    logic [10:0] m_q[$];
    int          m_to;
    logic        m_rda, m_cti, m_err, m_oe;
    logic        m_pen, m_pf64;

    function automatic int m_cap(input logic en, input logic f64);
        if (!en) return 1;
        if (!f64) return 16;
        return 64;
    endfunction

    function automatic int m_trig(input logic f64, input logic [1:0] t);
        int l16[4] = '{1, 4, 8, 14};
        int l64[4] = '{1, 16, 32, 56};
        return f64 ? l64[t] : l16[t];
    endfunction

    task automatic model_edge();
        int  nerr;
        bit  pop, push, full, was_empty, flush;
        if (RST) begin
            m_q.delete();
            m_to = 0; m_rda = 0; m_cti = 0; m_err = 0; m_oe = 0;
            m_pen = FIFO_EN; m_pf64 = FIFO64;
            return;
        end
        nerr = 0;
        foreach (m_q[i]) if (m_q[i][10:8] != 3'b000) nerr++;
        m_rda = FIFO_EN ? (m_q.size() >= m_trig(FIFO64, TRIG)) : (m_q.size() != 0);
        m_cti = (m_to == 4) && (m_q.size() != 0) && FIFO_EN;
        m_err = (nerr != 0) && FIFO_EN;
        flush = CLEAR || (FIFO_EN != m_pen) || (FIFO64 != m_pf64);
        m_oe  = 0;
        if (flush) begin
            m_q.delete();
            m_to = 0;
        end else begin
            was_empty = (m_q.size() == 0);
            full = (m_q.size() == m_cap(FIFO_EN, FIFO64));
            pop  = RD && !was_empty;
            push = RX_WE && (!full || pop);
            m_oe = RX_WE && full && !pop;
            if (pop) void'(m_q.pop_front());
            if (push) m_q.push_back(RX_DATA);
            if (push || pop || was_empty) m_to = 0;
            else if (CHAR_TICK && m_to < 4) m_to++;
        end
        m_pen = FIFO_EN; m_pf64 = FIFO64;
    endtask

    task automatic tick();
        @(posedge CLK);
        model_edge();
        #1;
    endtask

    task automatic push_val(input logic [10:0] v);
        RX_WE = 1; RX_DATA = v;
        tick();
        RX_WE = 0;
    endtask

    task automatic set_mode(input logic en, input logic f64, input logic [1:0] t);
        FIFO_EN = en; FIFO64 = f64; TRIG = t;
        tick(); tick();
    endtask

    task automatic drain();
        for (int i = 0; i < 70 && m_q.size() > 0; i++) begin
            RD = 1; tick();
        end
        RD = 0; tick(); tick();
    endtask

    // ------------------------------------------------------------------
    // Scenarios
    // ------------------------------------------------------------------
    task automatic test_reset();
        RST = 1; tick(); tick();
        checks++; if (DOUT !== 11'h0) begin failures++; $display("FAIL reset_dout got=%h exp=0", DOUT); end
        checks++; if (EMPTY !== 1'b1) begin failures++; $display("FAIL reset_empty got=%b exp=1", EMPTY); end
        checks++; if (FULL !== 1'b0) begin failures++; $display("FAIL reset_full got=%b exp=0", FULL); end
        checks++; if (COUNT !== 7'd0) begin failures++; $display("FAIL reset_count got=%0d exp=0", COUNT); end
        checks++; if ({RDA, CTI, OE, FIFO_ERR} !== 4'b0) begin failures++; $display("FAIL reset_flags got=%b exp=0000", {RDA, CTI, OE, FIFO_ERR}); end
        RST = 0; tick();
    endtask

    task automatic test_rda_trigger();
        set_mode(1, 1, 2);
        for (int i = 0; i < 31; i++) push_val(11'($urandom));
        tick(); tick();
        checks++; if (COUNT !== 7'd31) begin failures++; $display("FAIL rda_count31 got=%0d exp=31", COUNT); end
        checks++; if (RDA !== 1'b0) begin failures++; $display("FAIL rda_below got=%b exp=0", RDA); end
        push_val(11'($urandom));
        checks++; if (COUNT !== 7'd32) begin failures++; $display("FAIL rda_count32 got=%0d exp=32", COUNT); end
        checks++; if (RDA !== 1'b0) begin failures++; $display("FAIL rda_lag got=%b exp=0", RDA); end
        tick();
        checks++; if (RDA !== 1'b1) begin failures++; $display("FAIL rda_at_trig got=%b exp=1", RDA); end
        RD = 1; tick(); RD = 0; tick();
        checks++; if (RDA !== 1'b0) begin failures++; $display("FAIL rda_after_pop got=%b exp=0", RDA); end
        drain();
    endtask

    task automatic test_overrun();
        logic [10:0] vals[17];
        int oe_cnt = 0;
        set_mode(1, 0, 0);
        for (int i = 0; i < 17; i++) begin
            vals[i] = 11'($urandom);
            push_val(vals[i]);
            if (OE === 1'b1) oe_cnt++;
        end
        for (int i = 0; i < 3; i++) begin
            tick();
            if (OE === 1'b1) oe_cnt++;
        end
        checks++; if (oe_cnt != 1) begin failures++; $display("FAIL ovr_oe_pulses got=%0d exp=1", oe_cnt); end
        checks++; if (COUNT !== 7'd16) begin failures++; $display("FAIL ovr_count got=%0d exp=16", COUNT); end
        checks++; if (FULL !== 1'b1) begin failures++; $display("FAIL ovr_full got=%b exp=1", FULL); end
        for (int i = 0; i < 16; i++) begin
            checks++; if (DOUT !== vals[i]) begin failures++; $display("FAIL ovr_order idx=%0d got=%h exp=%h", i, DOUT, vals[i]); end
            RD = 1; tick(); RD = 0;
        end
        checks++; if (EMPTY !== 1'b1) begin failures++; $display("FAIL ovr_empty got=%b exp=1", EMPTY); end
        tick(); tick();
    endtask

    task automatic test_full_push_pop();
        logic [10:0] vals[17];
        set_mode(1, 0, 1);
        for (int i = 0; i < 16; i++) begin
            vals[i] = 11'($urandom);
            push_val(vals[i]);
        end
        vals[16] = 11'($urandom);
        RX_WE = 1; RD = 1; RX_DATA = vals[16];
        tick();
        RX_WE = 0; RD = 0;
        checks++; if (COUNT !== 7'd16) begin failures++; $display("FAIL fpp_count got=%0d exp=16", COUNT); end
        checks++; if (OE !== 1'b0) begin failures++; $display("FAIL fpp_oe got=%b exp=0", OE); end
        tick();
        checks++; if (OE !== 1'b0) begin failures++; $display("FAIL fpp_oe_late got=%b exp=0", OE); end
        for (int i = 1; i < 17; i++) begin
            checks++; if (DOUT !== vals[i]) begin failures++; $display("FAIL fpp_order idx=%0d got=%h exp=%h", i, DOUT, vals[i]); end
            RD = 1; tick(); RD = 0;
        end
        tick();
    endtask

    task automatic test_timeout();
        bit cti_seen = 0;
        set_mode(1, 0, 3);
        push_val(11'h0A5);
        CHAR_TICK = 1;
        for (int i = 0; i < 4; i++) tick();
        CHAR_TICK = 0;
        checks++; if (CTI !== 1'b0) begin failures++; $display("FAIL cti_early got=%b exp=0", CTI); end
        tick();
        checks++; if (CTI !== 1'b1) begin failures++; $display("FAIL cti_assert got=%b exp=1", CTI); end
        RD = 1; tick(); RD = 0;
        checks++; if (EMPTY !== 1'b1) begin failures++; $display("FAIL cti_empty got=%b exp=1", EMPTY); end
        tick();
        checks++; if (CTI !== 1'b0) begin failures++; $display("FAIL cti_deassert got=%b exp=0", CTI); end
        CHAR_TICK = 1;
        for (int i = 0; i < 10; i++) begin
            tick();
            if (CTI !== 1'b0) cti_seen = 1;
        end
        CHAR_TICK = 0;
        checks++; if (cti_seen) begin failures++; $display("FAIL cti_when_empty got=1 exp=0"); end
    endtask

    task automatic test_fifo_err();
        set_mode(1, 0, 0);
        push_val(11'h155);
        push_val(11'h041);
        tick();
        checks++; if (FIFO_ERR !== 1'b1) begin failures++; $display("FAIL ferr_set got=%b exp=1", FIFO_ERR); end
        RD = 1; tick(); RD = 0;
        tick();
        checks++; if (FIFO_ERR !== 1'b0) begin failures++; $display("FAIL ferr_clear got=%b exp=0", FIFO_ERR); end
        checks++; if (DOUT !== 11'h041) begin failures++; $display("FAIL ferr_head got=%h exp=041", DOUT); end
        drain();
    endtask

    task automatic test_clear();
        set_mode(1, 0, 0);
        for (int i = 0; i < 5; i++) push_val(11'($urandom));
        tick();
        checks++; if (RDA !== 1'b1) begin failures++; $display("FAIL clr_rda_before got=%b exp=1", RDA); end
        CLEAR = 1; RX_WE = 1; RX_DATA = 11'h07E;
        tick();
        CLEAR = 0; RX_WE = 0;
        checks++; if (COUNT !== 7'd0) begin failures++; $display("FAIL clr_count got=%0d exp=0", COUNT); end
        checks++; if (EMPTY !== 1'b1) begin failures++; $display("FAIL clr_empty got=%b exp=1", EMPTY); end
        tick();
        checks++; if (RDA !== 1'b0) begin failures++; $display("FAIL clr_rda got=%b exp=0", RDA); end
    endtask

    task automatic test_random();
        logic [10:0] e_dout;
        int rd_pct;
        for (int c = 0; c < 3000; c++) begin
            if (c % 300 == 0) begin
                FIFO_EN = ($urandom_range(0, 3) != 0);
                FIFO64  = $urandom_range(0, 1);
                TRIG    = 2'($urandom);
            end
            rd_pct    = ((c / 150) % 2 == 0) ? 20 : 70;
            RX_WE     = ($urandom_range(0, 99) < 50);
            RX_DATA   = 11'($urandom);
            RD        = ($urandom_range(0, 99) < rd_pct);
            CHAR_TICK = ($urandom_range(0, 99) < 40) && ($urandom_range(0, 9) == 0 || !RX_WE);
            CLEAR     = ($urandom_range(0, 199) == 0);
            tick();
            e_dout = (m_q.size() != 0) ? m_q[0] : 11'h0;
            checks++; if (DOUT !== e_dout) begin failures++; $display("FAIL rnd_dout cyc=%0d got=%h exp=%h", c, DOUT, e_dout); end
            checks++; if (COUNT !== 7'(m_q.size())) begin failures++; $display("FAIL rnd_count cyc=%0d got=%0d exp=%0d", c, COUNT, m_q.size()); end
            checks++; if (EMPTY !== (m_q.size() == 0)) begin failures++; $display("FAIL rnd_empty cyc=%0d got=%b", c, EMPTY); end
            checks++; if (FULL !== (m_q.size() == m_cap(FIFO_EN, FIFO64))) begin failures++; $display("FAIL rnd_full cyc=%0d got=%b", c, FULL); end
            checks++; if (RDA !== m_rda) begin failures++; $display("FAIL rnd_rda cyc=%0d got=%b exp=%b", c, RDA, m_rda); end
            checks++; if (CTI !== m_cti) begin failures++; $display("FAIL rnd_cti cyc=%0d got=%b exp=%b", c, CTI, m_cti); end
            checks++; if (OE !== m_oe) begin failures++; $display("FAIL rnd_oe cyc=%0d got=%b exp=%b", c, OE, m_oe); end
            checks++; if (FIFO_ERR !== m_err) begin failures++; $display("FAIL rnd_ferr cyc=%0d got=%b exp=%b", c, FIFO_ERR, m_err); end
        end
        RX_WE = 0; RD = 0; CHAR_TICK = 0; CLEAR = 0;
        tick();
    endtask

    task automatic test_reset_mid();
        set_mode(1, 1, 0);
        for (int i = 0; i < 10; i++) push_val(11'($urandom) | 11'h100);
        tick();
        RST = 1; RX_WE = 1; RD = 1; CLEAR = 1; RX_DATA = 11'h3FF;
        tick();
        RST = 0; RX_WE = 0; RD = 0; CLEAR = 0;
        checks++; if (DOUT !== 11'h0) begin failures++; $display("FAIL rstm_dout got=%h exp=0", DOUT); end
        checks++; if (EMPTY !== 1'b1) begin failures++; $display("FAIL rstm_empty got=%b exp=1", EMPTY); end
        checks++; if (FULL !== 1'b0) begin failures++; $display("FAIL rstm_full got=%b exp=0", FULL); end
        checks++; if (COUNT !== 7'd0) begin failures++; $display("FAIL rstm_count got=%0d exp=0", COUNT); end
        checks++; if ({RDA, CTI, OE, FIFO_ERR} !== 4'b0) begin failures++; $display("FAIL rstm_flags got=%b exp=0000", {RDA, CTI, OE, FIFO_ERR}); end
    endtask

    initial begin
        RST = 1; FIFO_EN = 1; FIFO64 = 1; TRIG = 0; CLEAR = 0;
        RX_WE = 0; RX_DATA = 0; RD = 0; CHAR_TICK = 0;
        test_reset();
        test_rda_trigger();
        test_overrun();
        test_full_push_pop();
        test_timeout();
        test_fifo_err();
        test_clear();
        test_random();
        test_reset_mid();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire
